debounce_scheduler: RTL

- Time-multiplexed debounce controller for a bank of N mechanical switches/buttons.
- Runs one shared 10 ms tick prescaler and one shared scan sequencer, instead of N independent tick counters and N debounce state machines.
- On each tick it visits every channel in turn, one per clock, updating that channel's stability counter and debounced level.
- Sits between raw board inputs and FSM/control logic; provides debounced levels plus one-cycle edge pulses.

---
 rtl/debounce_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: time-multiplexed debouncer for a bank of N switches.
// One shared tick prescaler and one scan sequencer visit each channel once per
// tick, one channel per clock, and update its stability counter and debounced
// level.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   sw       raw asynchronous switch levels (N bits)
//   en       per-channel enable; 0 forces the channel low and idle
//   db       debounced levels
//   rise     one-cycle pulse, coincident with db[i] going 0->1
//   fall     one-cycle pulse, coincident with db[i] going 1->0
//   busy     high while the sequencer is visiting channels
//   overrun  sticky flag: a tick arrived while one was already pending
module debounce_scheduler #(
  parameter int unsigned N            = 4,
  parameter int unsigned TICK_M       = 500_000,
  parameter int unsigned STABLE_TICKS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw,
  input  logic [N-1:0] en,
  output logic [N-1:0] db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         busy,
  output logic         overrun
);

  localparam int unsigned CntW = $clog2(STABLE_TICKS + 1);
  localparam int unsigned PreW = $clog2(TICK_M);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_M - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  typedef enum logic {StIdle, StScan} state_e;

  state_e          state_q;
  logic [N-1:0]    sync1_q;
  logic [N-1:0]    sample_q;
  logic [N-1:0]    db_q;
  logic [N-1:0]    rise_q;
  logic [N-1:0]    fall_q;
  logic [CntW-1:0] cnt_q [N];
  logic [PreW-1:0] presc_q;
  logic [IdxW-1:0] idx_q;
  logic            pending_q;
  logic            overrun_q;
  logic            tick;
  logic            last;

  assign tick = (presc_q == PreLast);
  assign last = (idx_q == IdxLast);

  // Two-flop synchronizer; sample_q is the level the scanner looks at.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sample_q <= '0;
    end else begin
      sync1_q  <= sw;
      sample_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      db_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            state_q <= StScan;
            idx_q   <= '0;
          end
        end
        StScan: begin
          // Visit channel idx_q.
          if (!en[idx_q]) begin
            db_q[idx_q]   <= 1'b0;
            cnt_q[idx_q]  <= '0;
            fall_q[idx_q] <= db_q[idx_q];
          end else if (sample_q[idx_q] == db_q[idx_q]) begin
            cnt_q[idx_q] <= '0;
          end else if (cnt_q[idx_q] == CntLast) begin
            db_q[idx_q]   <= ~db_q[idx_q];
            cnt_q[idx_q]  <= '0;
            rise_q[idx_q] <= ~db_q[idx_q];
            fall_q[idx_q] <= db_q[idx_q];
          end else begin
            cnt_q[idx_q] <= cnt_q[idx_q] + 1'b1;
          end

          // Sequencing. A tick landing on the last cycle with nothing pending
          // is consumed directly by restarting the scan.
          if (!last) begin
            idx_q <= idx_q + 1'b1;
          end else if (pending_q || tick) begin
            idx_q <= '0;
          end else begin
            state_q <= StIdle;
          end

          // Tick bookkeeping: one tick may wait, a second one is lost.
          if (tick) begin
            if (pending_q) begin
              overrun_q <= 1'b1;
            end else if (!last) begin
              pending_q <= 1'b1;
            end
          end
          if (last && pending_q) begin
            pending_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign db      = db_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign busy    = (state_q == StScan);
  assign overrun = overrun_q;

endmodule
